// File: rtl/match_alert_ctrl_pkg.sv
// Shared types and default widths for the match alert controller.
package match_alert_ctrl_pkg;

   localparam int DEF_PKT_ID_W = 16;
   localparam int DEF_IDX_W    = 12;
   localparam int DEF_CNT_W    = 32;

   // Cycles between a word entering the hash stage and its effect on match.
   // Hit capture assumes this is 1: the captured index is the previous word's.
   localparam int HASH_LAT     = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_TAIL,
      ST_CLEAR,
      ST_WAIT
   } state_t;

   // Alert record at default widths, {pkt_id, word_idx} packing.
   typedef struct packed {
      logic [DEF_PKT_ID_W-1:0] pkt_id;
      logic [DEF_IDX_W-1:0]    word_idx;
   } alert_rec_t;

endpackage

// File: rtl/match_alert_ctrl_if.sv
// Packet stream, hash-stage control and alert channel of the controller.
interface match_alert_ctrl_if
   import match_alert_ctrl_pkg::*;
#(
   parameter int PKT_ID_W = DEF_PKT_ID_W,
   parameter int IDX_W    = DEF_IDX_W
);
   logic                pkt_valid;
   logic                pkt_sop;
   logic                pkt_eop;
   logic                pkt_ready;
   logic                match;
   logic                match_en;
   logic                hash_rst;
   logic                alert_valid;
   logic                alert_ready;
   logic [PKT_ID_W-1:0] alert_pkt_id;
   logic [IDX_W-1:0]    alert_word_idx;

   // Environment side: upstream source, hash stage and host.
   modport master (
      output pkt_valid, pkt_sop, pkt_eop, match, alert_ready,
      input  pkt_ready, match_en, hash_rst, alert_valid, alert_pkt_id, alert_word_idx
   );

   // Controller side.
   modport slave (
      input  pkt_valid, pkt_sop, pkt_eop, match, alert_ready,
      output pkt_ready, match_en, hash_rst, alert_valid, alert_pkt_id, alert_word_idx
   );
endinterface

// File: rtl/match_alert_ctrl_fifo.sv
// First-word-fall-through FIFO. Entry 0 is always the head, so dout and
// valid come straight from flops. Push while full is accepted when a pop
// happens in the same cycle.
module alert_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]    count, count_nxt;
   logic             do_push, do_pop;
   logic [AW-1:0]    wr_slot;

   // Qualify requests; a new entry lands just past the surviving entries.
   always_comb begin
      do_pop    = pop & (count != '0);
      do_push   = push & ((count != CW'(DEPTH)) | do_pop);
      count_nxt = count + CW'(do_push) - CW'(do_pop);
      wr_slot   = AW'(count - CW'(do_pop));
   end

   // Storage: shift toward the head on pop, then write the new entry.
   always_ff @(posedge clk) begin
      if (do_pop) begin
         for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      if (do_push) mem[wr_slot] <= din;
   end

   // Occupancy and registered head-valid flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         valid <= 1'b0;
      end else begin
         count <= count_nxt;
         valid <= (count_nxt != '0);
      end
   end

   assign dout  = mem[0];
   assign full  = (count == CW'(DEPTH));
   assign empty = ~valid;

endmodule

// File: rtl/match_alert_ctrl.sv
// Framing tracker and alert generator behind the hash/bloom match stage.
// Enables matching per word, latches the first hit of each packet, queues
// an alert at packet end and resets the hash stage before the next packet.
module match_alert_ctrl
   import match_alert_ctrl_pkg::*;
#(
   parameter int PKT_ID_W    = DEF_PKT_ID_W,
   parameter int IDX_W       = DEF_IDX_W,
   parameter int ALERT_DEPTH = 4,
   parameter int CLEAR_WAIT  = 2,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   match_alert_ctrl_if.slave bus,
   output logic [CNT_W-1:0]  pkt_count,
   output logic [CNT_W-1:0]  alert_count,
   output logic [CNT_W-1:0]  drop_count,
   output logic [CNT_W-1:0]  err_count
);
   localparam int WAIT_W = (CLEAR_WAIT > 1) ? $clog2(CLEAR_WAIT) : 1;
   localparam int REC_W  = PKT_ID_W + IDX_W;

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    word_idx;   // index the next accepted word gets
   logic [IDX_W-1:0]    last_idx;   // index of the most recently accepted word
   logic [IDX_W-1:0]    hit_idx;
   logic                hit;
   logic [PKT_ID_W-1:0] pkt_id;
   logic [WAIT_W-1:0]   wait_cnt;

   logic rdy, men, start, scan_word, err, clr, capture_win;
   logic fifo_full, fifo_empty, fifo_push, fifo_pop, want_push;
   logic [REC_W-1:0] fifo_dout;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next state and per-cycle strobes.
   always_comb begin
      state_nxt   = state;
      rdy         = 1'b0;
      men         = 1'b0;
      start       = 1'b0;
      scan_word   = 1'b0;
      err         = 1'b0;
      clr         = 1'b0;
      capture_win = 1'b0;
      case (state)
         ST_IDLE: begin
            rdy = 1'b1;
            if (bus.pkt_valid) begin
               if (bus.pkt_sop) begin
                  men       = 1'b1;
                  start     = 1'b1;
                  state_nxt = bus.pkt_eop ? ST_TAIL : ST_SCAN;
               end else begin
                  err = 1'b1;  // stray word outside a packet
               end
            end
         end
         ST_SCAN: begin
            rdy         = 1'b1;
            men         = bus.pkt_valid;
            capture_win = 1'b1;
            if (bus.pkt_valid) begin
               scan_word = 1'b1;
               err       = bus.pkt_sop;  // nested sop is kept as payload
               if (bus.pkt_eop) state_nxt = ST_TAIL;
            end else begin
               err = 1'b1;  // bubble inside a packet
            end
         end
         ST_TAIL: begin
            capture_win = 1'b1;  // match for the eop word arrives now
            state_nxt   = ST_CLEAR;
         end
         ST_CLEAR: begin
            clr       = 1'b1;
            state_nxt = (CLEAR_WAIT == 0) ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (wait_cnt == WAIT_W'(CLEAR_WAIT - 1)) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Word indexing, first-hit capture, packet id and settle counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_idx <= '0;
         last_idx <= '0;
         hit      <= 1'b0;
         hit_idx  <= '0;
         pkt_id   <= '0;
         wait_cnt <= '0;
      end else begin
         if (start) begin
            word_idx <= IDX_W'(1);
            last_idx <= '0;
            hit      <= 1'b0;
         end else if (scan_word) begin
            last_idx <= word_idx;
            if (~&word_idx) word_idx <= word_idx + IDX_W'(1);
         end
         // match lags its word by one cycle, so last_idx names the hit word
         if (capture_win && bus.match && !hit) begin
            hit     <= 1'b1;
            hit_idx <= last_idx;
         end
         if (clr) pkt_id <= pkt_id + PKT_ID_W'(1);
         if (state == ST_WAIT) wait_cnt <= wait_cnt + WAIT_W'(1);
         else                  wait_cnt <= '0;
      end
   end

   assign fifo_pop  = bus.alert_ready & ~fifo_empty;
   assign want_push = clr & hit;
   assign fifo_push = want_push & (~fifo_full | fifo_pop);

   // Saturating statistics.
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_count   <= '0;
         alert_count <= '0;
         drop_count  <= '0;
         err_count   <= '0;
      end else begin
         if (err && ~&err_count) err_count <= err_count + CNT_W'(1);
         if (clr && ~&pkt_count) pkt_count <= pkt_count + CNT_W'(1);
         if (fifo_push && ~&alert_count) alert_count <= alert_count + CNT_W'(1);
         if (want_push && !fifo_push && ~&drop_count) drop_count <= drop_count + CNT_W'(1);
      end
   end

   alert_fifo #(
      .DEPTH (ALERT_DEPTH),
      .WIDTH (REC_W)
   ) u_alert_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   ({pkt_id, hit_idx}),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .valid (bus.alert_valid),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Reset gates the handshake off and holds the hash stage in reset.
   assign bus.pkt_ready      = rdy & ~rst;
   assign bus.match_en       = men & ~rst;
   assign bus.hash_rst       = rst | clr;
   assign bus.alert_pkt_id   = fifo_dout[REC_W-1:IDX_W];
   assign bus.alert_word_idx = fifo_dout[IDX_W-1:0];

endmodule

// File: tb/tb_match_alert_ctrl.sv
// Bench for match_alert_ctrl: cycle table, directed corner sequences and
// randomized packets scored against a packet-level model.
module tb_match_alert_ctrl;
   import match_alert_ctrl_pkg::*;

   localparam int PKT_ID_W    = 16;
   localparam int IDX_W       = 12;
   localparam int ALERT_DEPTH = 4;
   localparam int CLEAR_WAIT  = 2;
   localparam int CNT_W       = 32;
   localparam int MAX_IDX     = (1 << IDX_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [CNT_W-1:0] pkt_count, alert_count, drop_count, err_count;

   match_alert_ctrl_if #(.PKT_ID_W(PKT_ID_W), .IDX_W(IDX_W)) bus ();

   match_alert_ctrl #(
      .PKT_ID_W(PKT_ID_W), .IDX_W(IDX_W), .ALERT_DEPTH(ALERT_DEPTH),
      .CLEAR_WAIT(CLEAR_WAIT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .pkt_count(pkt_count), .alert_count(alert_count),
      .drop_count(drop_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Hash stage stand-in: sticky match one cycle after an enabled hit word.
   logic hit_word = 1'b0;
   logic stage_match = 1'b0;
   always @(posedge clk) begin
      if (bus.hash_rst) stage_match <= 1'b0;
      else if (bus.pkt_valid && bus.match_en && hit_word) stage_match <= 1'b1;
   end
   assign bus.match = stage_match;

   int n_chk = 0;
   int n_pass = 0;

   // Packet-level model (valid while the host is not popping).
   alert_rec_t exp_q[$];
   int m_pid, m_pkts, m_alerts, m_drops, m_errs;

   typedef struct packed {
      bit v, s, e, h;
      bit rdy, men, hrst;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(string name, longint act, longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit v, bit s, bit e, bit h);
      bus.pkt_valid = v;
      bus.pkt_sop   = s;
      bus.pkt_eop   = e;
      hit_word      = h;
   endtask

   task automatic idle_in();
      drive(0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_in();
      bus.alert_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      exp_q.delete();
      m_pid = 0; m_pkts = 0; m_alerts = 0; m_drops = 0; m_errs = 0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.pkt_ready && n < 20) begin
         tick();
         n++;
      end
      if (!bus.pkt_ready) chk("ready_timeout", bus.pkt_ready, 1);
   endtask

   // Send one packet; hit_at = word whose hash hits (-1 none), bub_at = bubble
   // before that word, sop_at = extra sop on that word, stray = lone word first.
   task automatic send_pkt(int len, int hit_at, int bub_at, int sop_at, bit stray);
      alert_rec_t rec;
      wait_ready();
      if (stray) begin
         drive(1, 0, 0, 0);
         tick();
         m_errs++;
      end
      for (int i = 0; i < len; i++) begin
         if (i == bub_at && i > 0) begin
            idle_in();
            tick();
            m_errs++;
         end
         drive(1, (i == 0) || (i == sop_at), i == len - 1, i == hit_at);
         tick();
         if (i > 0 && i == sop_at) m_errs++;
      end
      idle_in();
      m_pkts++;
      if (hit_at >= 0) begin
         rec.pkt_id   = PKT_ID_W'(m_pid);
         rec.word_idx = IDX_W'((hit_at > MAX_IDX) ? MAX_IDX : hit_at);
         if (exp_q.size() < ALERT_DEPTH) begin
            exp_q.push_back(rec);
            m_alerts++;
         end else begin
            m_drops++;
         end
      end
      m_pid = (m_pid + 1) % (1 << PKT_ID_W);
   endtask

   task automatic chk_counts(string tag);
      repeat (CLEAR_WAIT + 3) tick();
      chk({tag, "_pkt_count"}, pkt_count, m_pkts);
      chk({tag, "_alert_count"}, alert_count, m_alerts);
      chk({tag, "_drop_count"}, drop_count, m_drops);
      chk({tag, "_err_count"}, err_count, m_errs);
   endtask

   task automatic drain(string tag);
      alert_rec_t e;
      int n = 0;
      bus.alert_ready = 1'b1;
      while (bus.alert_valid && n < ALERT_DEPTH + 2) begin
         if (exp_q.size() == 0) chk({tag, "_extra_alert"}, bus.alert_valid, 0);
         else begin
            e = exp_q.pop_front();
            chk({tag, "_alert_id"}, bus.alert_pkt_id, e.pkt_id);
            chk({tag, "_alert_idx"}, bus.alert_word_idx, e.word_idx);
         end
         tick();
         n++;
      end
      tick();  // pop against an empty FIFO
      bus.alert_ready = 1'b0;
      chk({tag, "_alerts_missing"}, exp_q.size(), 0);
      chk({tag, "_fifo_empty"}, bus.alert_valid, 0);
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      alert_rec_t rec;
      alert_rec_t last;
      // single-word hit packet, stray word, packet with nested sop hitting on word 1
      tbl.push_back('{1,1,1,1, 1,1,0});
      tbl.push_back('{0,0,0,0, 0,0,0});
      tbl.push_back('{0,0,0,0, 0,0,1});
      tbl.push_back('{0,0,0,0, 0,0,0});
      tbl.push_back('{0,0,0,0, 0,0,0});
      tbl.push_back('{1,0,0,0, 1,0,0});
      tbl.push_back('{1,1,0,0, 1,1,0});
      tbl.push_back('{1,1,0,1, 1,1,0});
      tbl.push_back('{1,0,1,0, 1,1,0});
      tbl.push_back('{0,0,0,0, 0,0,0});
      tbl.push_back('{0,0,0,0, 0,0,1});
      tbl.push_back('{0,0,0,0, 0,0,0});
      tbl.push_back('{0,0,0,0, 0,0,0});
      tbl.push_back('{0,0,0,0, 1,0,0});

      // reset state, with a sop word pushed at the DUT
      rst = 1'b1;
      bus.alert_ready = 1'b0;
      drive(1, 1, 0, 0);
      repeat (2) tick();
      chk("rst_pkt_ready", bus.pkt_ready, 0);
      chk("rst_match_en", bus.match_en, 0);
      chk("rst_hash_rst", bus.hash_rst, 1);
      chk("rst_alert_valid", bus.alert_valid, 0);
      chk("rst_err_count", err_count, 0);
      idle_in();
      rst = 1'b0;
      #1;
      chk("rel_pkt_ready", bus.pkt_ready, 1);
      chk("rel_hash_rst", bus.hash_rst, 0);

      // cycle table
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].h);
         #1;
         chk($sformatf("tbl%0d_pkt_ready", i), bus.pkt_ready, tbl[i].rdy);
         chk($sformatf("tbl%0d_match_en", i), bus.match_en, tbl[i].men);
         chk($sformatf("tbl%0d_hash_rst", i), bus.hash_rst, tbl[i].hrst);
         tick();
      end
      idle_in();
      tick();
      chk("tbl_err_count", err_count, 2);
      chk("tbl_pkt_count", pkt_count, 2);
      chk("tbl_alert_count", alert_count, 2);
      rec.pkt_id = 0; rec.word_idx = 0; exp_q.push_back(rec);
      rec.pkt_id = 1; rec.word_idx = 1; exp_q.push_back(rec);
      drain("tbl");

      // 4-word packet, hit on word 2; hash_rst two cycles after eop
      do_reset();
      send_pkt(4, 2, -1, -1, 0);
      chk("p4_tail_hash_rst", bus.hash_rst, 0);
      chk("p4_tail_pkt_ready", bus.pkt_ready, 0);
      tick();
      chk("p4_clear_hash_rst", bus.hash_rst, 1);
      tick();
      chk("p4_wait_hash_rst", bus.hash_rst, 0);
      chk_counts("p4");
      drain("p4");

      // six hitting packets with the host stalled
      do_reset();
      for (int p = 0; p < 6; p++) send_pkt(p + 1, p, -1, -1, 0);
      chk_counts("full");
      chk("full_drop_count", drop_count, 2);
      chk("full_alert_count", alert_count, 4);
      drain("full");

      // push into a full FIFO in the same cycle as a pop
      do_reset();
      for (int p = 0; p < 4; p++) send_pkt(2, 1, -1, -1, 0);
      send_pkt(3, 0, -1, -1, 0);
      tick();  // now in the cycle that pushes
      chk("pp_head_id", bus.alert_pkt_id, 0);
      bus.alert_ready = 1'b1;
      tick();
      bus.alert_ready = 1'b0;
      void'(exp_q.pop_front());
      last.pkt_id = 4; last.word_idx = 0;
      exp_q.push_back(last);
      m_drops--; m_alerts++;
      chk_counts("pp");
      chk("pp_drop_count", drop_count, 0);
      drain("pp");

      // miss then hit
      do_reset();
      send_pkt(3, -1, -1, -1, 0);
      send_pkt(5, 4, -1, -1, 0);
      chk_counts("miss");
      drain("miss");

      // word index saturation
      do_reset();
      send_pkt(MAX_IDX + 5, MAX_IDX + 4, -1, -1, 0);
      chk_counts("sat");
      drain("sat");

      // reset in the middle of a hitting packet
      do_reset();
      send_pkt(2, 0, -1, -1, 1);
      repeat (CLEAR_WAIT + 2) tick();
      wait_ready();
      drive(1, 1, 0, 1); tick();
      drive(1, 0, 0, 0); tick();
      drive(1, 0, 0, 0); tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_hash_rst", bus.hash_rst, 1);
      chk("mid_rst_pkt_ready", bus.pkt_ready, 0);
      chk("mid_rst_match_en", bus.match_en, 0);
      repeat (2) tick();
      chk("mid_rst_hash_rst_held", bus.hash_rst, 1);
      idle_in();
      rst = 1'b0;
      #1;
      chk("mid_rel_pkt_ready", bus.pkt_ready, 1);
      chk("mid_rel_pkt_count", pkt_count, 0);
      chk("mid_rel_alert_count", alert_count, 0);
      chk("mid_rel_err_count", err_count, 0);
      chk("mid_rel_alert_valid", bus.alert_valid, 0);
      repeat (6) tick();
      chk("mid_late_alert_valid", bus.alert_valid, 0);
      chk("mid_late_pkt_count", pkt_count, 0);

      // randomized bursts, host stalled during each burst
      do_reset();
      for (int b = 0; b < 8; b++) begin
         int nb;
         nb = $urandom_range(1, 7);
         for (int p = 0; p < nb; p++) begin
            int len, h, bu, so;
            bit st;
            len = $urandom_range(1, 8);
            h   = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, len - 1));
            bu  = (len > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, len - 1)) : -1;
            so  = (len > 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, len - 1)) : -1;
            st  = ($urandom_range(0, 3) == 0);
            send_pkt(len, h, bu, so, st);
         end
         chk_counts($sformatf("rnd%0d", b));
         drain($sformatf("rnd%0d", b));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/match_alert_ctrl.md
Name: match_alert_ctrl

Overview:
- Sits directly downstream of the 64-bit hash/bloom match stage. Its sibling outputs are also wired back into that stage's control inputs.
- Tracks packet framing of the word stream fed to the hash stage and drives match_en. It captures the stage's sticky match flag per packet.
- At each packet end it pushes an alert record (packet id, word index of first hit) into a small FIFO toward the host. It then pulses hash_rst to clear the stage's history and sticky match before the next packet.
- Keeps saturating statistics counters.

Parameters:
- PKT_ID_W, 16, width of packet id counter / alert id field
- IDX_W, 12, width of word-index counter (max words per packet 2^IDX_W-1)
- ALERT_DEPTH, 4, alert FIFO depth (power of 2, >=2)
- CLEAR_WAIT, 2, idle cycles after hash_rst before next sop is accepted (covers the stage's registered reset)
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pkt_valid  in  1  word valid, aligned with in_data presented to hash stage
- pkt_sop  in  1  first word of packet (qualified by pkt_valid)
- pkt_eop  in  1  last word of packet (qualified by pkt_valid)
- pkt_ready  out  1  upstream may present a word this cycle
- match  in  1  sticky match from hash stage (valid 1 cycle after word)
- match_en  out  1  hash stage match enable
- hash_rst  out  1  reset pulse to hash stage
- alert_valid  out  1  alert FIFO head valid
- alert_ready  in  1  host consumes head when valid&ready
- alert_pkt_id  out  PKT_ID_W  packet id of head alert
- alert_word_idx  out  IDX_W  word index of first hit in that packet
- pkt_count  out  CNT_W  packets completed (saturating)
- alert_count  out  CNT_W  alerts pushed (saturating)
- drop_count  out  CNT_W  alerts dropped, FIFO full (saturating)
- err_count  out  CNT_W  framing errors (saturating)

Behaviour:
- Reset (sync, active-high): state IDLE; pkt_id=0; FIFO emptied; all counters 0; match_en=0; alert_valid=0; pkt_ready=0 while rst=1. hash_rst = rst OR FSM pulse, so it is high throughout reset. pkt_ready=1 on the first cycle after reset release.
- Reset mid-operation: the packet is abandoned with no alert and no pkt_count increment.
- States: IDLE, SCAN, TAIL, CLEAR, WAIT.
- IDLE: pkt_ready=1. On pkt_valid&pkt_sop: word_idx=0, last_idx=0, hit=0, match_en=1 that cycle. Go to SCAN, or to TAIL if pkt_eop is also set (single-word packet). pkt_valid without sop: word discarded, match_en=0, err_count+1.
- SCAN: pkt_ready=1. match_en = pkt_valid. Each valid word increments word_idx; last_idx holds the index of the most recently accepted word. pkt_valid&pkt_eop moves to TAIL. pkt_valid&pkt_sop in SCAN: err_count+1, the word is treated as payload. A pkt_valid=0 cycle inside a packet: err_count+1, match_en=0, and the FSM stays in SCAN.
- Hit capture (SCAN and TAIL): when match=1 and hit=0, set hit=1 and hit_idx=last_idx. last_idx here is the index of the word presented one cycle earlier, because of the stage's 1-cycle latency. Once hit=1, later match values are ignored.
- TAIL: one cycle. pkt_ready=0, match_en=0. Samples match for the eop word, then goes to CLEAR.
- CLEAR: one cycle. hash_rst=1, pkt_ready=0, pkt_count+1.
  - If hit and FIFO not full: push {pkt_id, hit_idx}, alert_count+1.
  - If hit and FIFO full: no push, drop_count+1.
  - pkt_id increments (wraps at 2^PKT_ID_W) regardless of hit.
- WAIT: pkt_ready=0 for CLEAR_WAIT cycles, then IDLE.
- Per-packet overhead is 2+CLEAR_WAIT cycles of pkt_ready=0 after eop.
- word_idx saturates at 2^IDX_W-1 and does not wrap.
- Alert FIFO: first-word-fall-through, registered outputs. A simultaneous push and pop when full is allowed, with no drop. A pop when empty is ignored.
- All counters saturate at all-ones.

Decomposition:
- nids_pkg: FSM state enum; alert record struct {pkt_id, word_idx}; default widths PKT_ID_W, IDX_W, CNT_W; hash-stage latency constant HASH_LAT=1.
- One sub-module, alert_fifo: synchronous FWFT FIFO, parameterised depth and width, with full/empty flags.

Test Plan:
- 4-word packet, match rises on the cycle after word 2 -> one alert {pkt_id=0, word_idx=2}; hash_rst high exactly one cycle, 2 cycles after the eop word; pkt_count=1.
- Single-word packet (sop&eop), match=1 in TAIL -> alert {0, 0}; state goes IDLE→TAIL→CLEAR→WAIT(2)→IDLE; pkt_ready low for 4 cycles.
- 6 packets all hitting, alert_ready=0 -> 4 alerts queued, drop_count=2, alert_count=4; draining gives pkt_ids 0..3 in order.
- Packet with no match, followed by a hitting packet -> no alert for pkt_id 0; alert pkt_id=1; pkt_count=2.
- pkt_valid without sop in IDLE, then sop during SCAN -> err_count=2, match_en=0 on the stray word, the packet completes normally.
- rst asserted mid-SCAN with hit=1 -> no alert, all counters 0, hash_rst high during reset, pkt_ready=1 on the first cycle after release.
